// File: rtl/encoder_emulator_if.sv
// Command/status bundle between the encoder emulator and its C-side register block.
// master drives the run-time configuration; slave is the emulator itself.
interface encoder_emulator_if;
  logic        enable;
  logic        dir;
  logic [31:0] step_period;
  logic [31:0] pulses_per_rev;
  logic        trigger;
  logic        A;
  logic        B;
  logic        Z;
  logic [31:0] steps;
  logic [31:0] position;
  logic [31:0] steps_synced;
  logic [31:0] position_synced;
  logic        done;

  modport master (
    output enable, dir, step_period, pulses_per_rev, trigger,
    input  A, B, Z, steps, position, steps_synced, position_synced, done
  );

  modport slave (
    input  enable, dir, step_period, pulses_per_rev, trigger,
    output A, B, Z, steps, position, steps_synced, position_synced, done
  );
endinterface

// File: rtl/encoder_emulator.sv
// Quadrature encoder emulator: produces A/B/Z at a commanded step rate and direction,
// tracks signed step count and single-revolution position, and snapshots both on trigger.
module encoder_emulator (
  input  logic                clk,
  input  logic                rst_n,
  encoder_emulator_if.slave   bus
);
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S10 = 2'b10,
    S11 = 2'b11
  } quad_t;

  quad_t                    state_q;
  quad_t                    state_d;
  logic [1:0]               ab;
  logic [DATA_W-1:0]        cnt;
  logic [DATA_W-1:0]        period_act;
  logic [DATA_W-1:0]        max_pos;
  logic [DATA_W-1:0]        position;
  logic [DATA_W-1:0]        pos_next;
  logic signed [DATA_W-1:0] steps;
  logic signed [DATA_W-1:0] steps_next;
  logic [DATA_W-1:0]        steps_synced;
  logic [DATA_W-1:0]        position_synced;
  logic                     z;
  logic                     done;
  logic                     step_evt;

  // Forward wrap also catches a position left above the limit after pulses_per_rev shrinks.
  function automatic logic [DATA_W-1:0] pos_up(input logic [DATA_W-1:0] pos,
                                               input logic [DATA_W-1:0] lim);
    return (pos >= lim) ? '0 : pos + DATA_W'(1);
  endfunction

  function automatic logic [DATA_W-1:0] pos_down(input logic [DATA_W-1:0] pos,
                                                 input logic [DATA_W-1:0] lim);
    return ((pos == '0) || (pos > lim)) ? lim : pos - DATA_W'(1);
  endfunction

  // pulses_per_rev of 0 means a full 2^32 revolution, so the modulo wrap is intended.
  assign max_pos  = bus.pulses_per_rev - DATA_W'(1);
  assign step_evt = bus.enable && (period_act != '0) && (cnt == period_act - DATA_W'(1));

  // Prescaler: period_act only re-latches while idle or on a step, so edits apply next period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      period_act <= '0;
    end else if (!bus.enable) begin
      cnt        <= '0;
      period_act <= bus.step_period;
    end else if (step_evt) begin
      cnt        <= '0;
      period_act <= bus.step_period;
    end else if (period_act == '0) begin
      cnt        <= '0;
    end else begin
      cnt        <= cnt + DATA_W'(1);
    end
  end

  // Quadrature state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S00;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (step_evt) begin
      if (bus.dir) begin
        case (state_q)
          S00:     state_d = S10;
          S10:     state_d = S11;
          S11:     state_d = S01;
          default: state_d = S00;
        endcase
      end else begin
        case (state_q)
          S00:     state_d = S01;
          S01:     state_d = S11;
          S11:     state_d = S10;
          default: state_d = S00;
        endcase
      end
    end
  end

  assign ab = state_q;

  always_comb begin
    pos_next   = position;
    steps_next = steps;
    if (step_evt) begin
      if (bus.dir) begin
        pos_next   = pos_up(position, max_pos);
        steps_next = steps + 32'sd1;
      end else begin
        pos_next   = pos_down(position, max_pos);
        steps_next = steps - 32'sd1;
      end
    end
  end

  // Counters and index: Z follows the post-edge position so it changes with A/B
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      position <= '0;
      steps    <= '0;
      z        <= 1'b0;
    end else begin
      position <= pos_next;
      steps    <= steps_next;
      z        <= (pos_next == '0);
    end
  end

  // Snapshot: captures register values from before any same-edge step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      steps_synced    <= '0;
      position_synced <= '0;
      done            <= 1'b0;
    end else begin
      done <= bus.trigger;
      if (bus.trigger) begin
        steps_synced    <= steps;
        position_synced <= position;
      end
    end
  end

  assign bus.A               = ab[1];
  assign bus.B               = ab[0];
  assign bus.Z               = z;
  assign bus.steps           = steps;
  assign bus.position        = position;
  assign bus.steps_synced    = steps_synced;
  assign bus.position_synced = position_synced;
  assign bus.done            = done;
endmodule

// File: doc/encoder_emulator.md
# encoder_emulator

Quadrature encoder emulator: generates A/B/Z signals as an incremental encoder of configurable resolution rotating at a commanded step rate and direction. It sits in the AMDC FPGA as a signal source for hardware-in-the-loop testing: its outputs can drive an encoder input pin or loop back into the encoder decoder. It keeps its own step count and single-revolution position, and latches both on a control-loop trigger, in the same way as the decoder.

## Interface
- No parameters; all configuration is through run-time inputs written from C code.
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- enable  input  1  1 = emulate rotation; 0 = hold all outputs.
- dir  input  1  1 = forward (count up), 0 = reverse.
- step_period  input  32  clocks per quadrature step; 0 = no stepping.
- pulses_per_rev  input  32  quadrature steps per revolution; 0 means 2^32.
- trigger  input  1  one-clock pulse that snapshots counters.
- A, B, Z  output  1 each  registered quadrature and index outputs.
- steps  output  32  signed running step count.
- position  output  32  single-revolution position, 0 to pulses_per_rev-1.
- steps_synced, position_synced  output  32 each  values latched on trigger.
- done  output  1  one-clock pulse after a snapshot.

## Operation
- **Prescaler:** 32-bit `cnt` and latched `period_act`.
  - `period_act` loads `step_period` on every clock while `enable` = 0 and on every step event. A mid-run change takes effect after the next step.
  - Step event: `enable` = 1, `period_act` != 0 and `cnt` == `period_act` - 1. `cnt` then returns to 0; otherwise `cnt` increments.
  - With `enable` = 0 or `period_act` = 0, `cnt` is held at 0.
- **Quadrature state machine:** states S00, S10, S11, S01, encoded {A,B}.
  - Forward: S00→S10→S11→S01→S00.
  - Reverse: the exact inverse sequence.
  - Exactly one of A/B toggles per step event; the state never changes without one. `dir` is sampled at the step event.
- **position:**
  - Forward step: +1, wrapping (pulses_per_rev-1)→0.
  - Reverse step: -1, wrapping 0→(pulses_per_rev-1).
  - MAX_POS = pulses_per_rev - 1, computed modulo 2^32, so 0 gives 32'hFFFFFFFF.
  - If `position` > MAX_POS (pulses_per_rev reduced at run time), the next forward step goes to 0 and the next reverse step goes to MAX_POS.
- **steps:** +1 on a forward step, -1 on a reverse step, modulo 2^32 two's complement.
- **Z:** registered.
  - On a step edge, Z loads (next position == 0). On other edges, Z loads (position == 0).
  - Z is therefore high for exactly the steps spent at position 0, and its edges are aligned with the A/B edges.
- **Snapshot:** on `trigger`, `steps_synced` and `position_synced` load the current register values (their values before any same-edge step) and `done` = 1 for one clock. Otherwise these outputs hold and `done` = 0.

## Timing
- Reset values: A=0, B=0, Z=0, steps=0, position=0, cnt=0, period_act=0, steps_synced=0, position_synced=0, done=0. Quadrature state S00.
- Z rises on the first clock after reset release, because position is 0. The step state machine is not involved.
- Latency:
  - First step occurs on the Nth rising edge with `enable` sampled high, N = `period_act`.
  - Subsequent steps follow exactly every N clocks. N = 1 gives one step per clock.
  - A, B, Z, position and steps all update on the same edge.
- Dropping `enable` mid-period discards the partial count; re-enabling restarts a full period.
- Changing `dir` between steps reverses the sequence at the next step without skipping a state.
- Trigger on the same edge as a step latches the pre-step values; the step still happens.
- Asserting `rst_n` low mid-operation immediately forces all reset values, without waiting for a clock.
- The output sequence must decode losslessly in the encoder decoder for any N >= 1. That block has a 2-flop synchronizer and an up/down state machine that accepts one transition per clock.

## Test plan
- **Forward run:** step_period=3, pulses_per_rev=8, dir=1, enable for 30 clocks.
  - {A,B} steps through 00,10,11,01,... every 3 clocks.
  - steps=10 and position=2.
  - Z is high only while position=0.
- **Reverse wrap from reset:** step_period=1, pulses_per_rev=4, dir=0, 3 clocks.
  - position goes 3,2,1; steps = -3 (32'hFFFFFFFD).
  - {A,B} goes 01,11,10.
  - Z falls on the first step.
- **Direction flip mid-run:** forward 5 steps, then dir=0 for 5 steps.
  - steps and position return to 0 and {A,B}=00.
  - No state is skipped; a loopback decoder reports counter=0.
- **Period change and stop:**
  - step_period changed 4→2 mid-period: the current period completes at 4, later periods are 2.
  - step_period=0: no steps for 100 clocks.
- **Snapshot and reset:**
  - trigger on a step edge: synced values equal the pre-step values and done is high for exactly 1 clock.
  - rst_n low mid-run: all outputs match the reset values asynchronously.
- **Loopback:** 10,000 random dir/period (1..7) steps fed to the decoder.
  - Decoder counter equals `steps` after 3 settling clocks.
  - After the first index, decoder position equals `position`.
